rr_onehot_arbiter: RTL and testbench

- 16-requester round-robin arbiter that issues a registered one-hot grant with a qualifying valid flag.
- It sits directly upstream of the 16-to-4 one-hot encoder. `grant` drives the encoder input and `grant_valid` drives the encoder enable, so the encoder always sees either all-zero or exactly one bit set.
- Each grant is held until the owner releases, the owner drops its request, or an optional hold timeout expires.

---
 rtl/rr_onehot_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter
//   Round-robin arbiter for 16 requesters. It produces a registered one-hot
//   grant that feeds a 16-to-4 one-hot encoder. The arbiter holds a grant
//   until one of three things happens: the owner strobes done, the owner
//   drops its request, or the optional hold timeout expires. One all-zero
//   cycle always separates two grants.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req[15:0]   request levels; bit i = requester i wants the resource
//   done        single-cycle release strobe from the current owner
//   grant[15:0] registered one-hot grant; zero when no grant is active
//   grant_valid high exactly when grant is non-zero
//   timeout     one-cycle pulse after a grant is revoked by the hold timeout
module rr_onehot_arbiter #(
    parameter int N        = 16,
    parameter int HOLD_MAX = 0,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);

    localparam int IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
    logic [N-1:0]       grant_n;
    logic               timeout_n;

    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   idx;
    logic               timed_out;
    logic               release_now;

    // Priority scan starting at ptr, wrapping modulo N via IDX_W-bit add.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        timed_out   = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM) && !done && req[owner];
        release_now = done || !req[owner] || timed_out;
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        hold_cnt_n = hold_cnt;
        grant_n    = grant;
        timeout_n  = 1'b0;

        unique case (state)
            IDLE: begin
                grant_n = '0;
                if (found) begin
                    grant_n[sel] = 1'b1;
                    owner_n      = sel;
                    hold_cnt_n   = CNT_W'(1);
                    state_n      = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_n   = '0;
                    state_n   = IDLE;
                    ptr_n     = owner + IDX_W'(1);
                    timeout_n = timed_out;
                end else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            hold_cnt <= hold_cnt_n;
            grant    <= grant_n;
            timeout  <= timeout_n;
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter
//   Directed bench for rr_onehot_arbiter. Two instances share inputs: dut0
//   with the hold timeout disabled and dut4 with HOLD_MAX=4.
module tb_rr_onehot_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;

    logic [15:0] g0, g4;
    logic        v0, v4, t0, t4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N(16), .HOLD_MAX(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(g0), .grant_valid(v0), .timeout(t0)
    );

    rr_onehot_arbiter #(.N(16), .HOLD_MAX(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(g4), .grant_valid(v4), .timeout(t4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (g0 !== 16'h0000) begin n_fail++; $display("FAIL reset_grant0: got %h want 0000", g0); end
        n_checks++; if (v0 !== 1'b0)     begin n_fail++; $display("FAIL reset_valid0: got %b want 0", v0); end
        n_checks++; if (t0 !== 1'b0)     begin n_fail++; $display("FAIL reset_timeout0: got %b want 0", t0); end
        n_checks++; if (g4 !== 16'h0000) begin n_fail++; $display("FAIL reset_grant4: got %h want 0000", g4); end
        n_checks++; if (v4 !== 1'b0)     begin n_fail++; $display("FAIL reset_valid4: got %b want 0", v4); end
        n_checks++; if (t4 !== 1'b0)     begin n_fail++; $display("FAIL reset_timeout4: got %b want 0", t4); end
    endtask

    task automatic test_idle();
        do_reset();
        req = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (g0 !== 16'h0000) begin n_fail++; $display("FAIL idle_grant c%0d: got %h want 0000", i, g0); end
            n_checks++; if (v0 !== 1'b0)     begin n_fail++; $display("FAIL idle_valid c%0d: got %b want 0", i, v0); end
            n_checks++; if (t0 !== 1'b0)     begin n_fail++; $display("FAIL idle_timeout c%0d: got %b want 0", i, t0); end
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 16'h0101;                       // cycle 0
        step();                               // cycle 1
        n_checks++; if (g0 !== 16'h0001) begin n_fail++; $display("FAIL basic_first: got %h want 0001", g0); end
        n_checks++; if (v0 !== 1'b1)     begin n_fail++; $display("FAIL basic_valid: got %b want 1", v0); end
        step();                               // cycle 2
        n_checks++; if (g0 !== 16'h0001) begin n_fail++; $display("FAIL basic_hold: got %h want 0001", g0); end
        step();                               // cycle 3
        done = 1'b1;
        step();                               // cycle 4
        done = 1'b0;
        n_checks++; if (g0 !== 16'h0000) begin n_fail++; $display("FAIL basic_gap: got %h want 0000", g0); end
        n_checks++; if (v0 !== 1'b0)     begin n_fail++; $display("FAIL basic_gap_valid: got %b want 0", v0); end
        step();                               // cycle 5
        n_checks++; if (g0 !== 16'h0100) begin n_fail++; $display("FAIL basic_second: got %h want 0100", g0); end
    endtask

    task automatic test_no_timeout_when_disabled();
        // dut0 must keep the grant well past 4 cycles.
        do_reset();
        req = 16'h0003;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++; if (g0 !== 16'h0001) begin n_fail++; $display("FAIL notimeout_grant c%0d: got %h want 0001", i, g0); end
            n_checks++; if (t0 !== 1'b0)     begin n_fail++; $display("FAIL notimeout_pulse c%0d: got %b want 0", i, t0); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h8000;
        step();
        n_checks++; if (g0 !== 16'h8000) begin n_fail++; $display("FAIL wrap_g15: got %h want 8000", g0); end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 16'h8001;
        n_checks++; if (g0 !== 16'h0000) begin n_fail++; $display("FAIL wrap_gap: got %h want 0000", g0); end
        step();
        n_checks++; if (g0 !== 16'h0001) begin n_fail++; $display("FAIL wrap_next: got %h want 0001", g0); end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 16'h0003;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (g4 !== 16'h0001) begin n_fail++; $display("FAIL timeout_hold c%0d: got %h want 0001", i, g4); end
            n_checks++; if (t4 !== 1'b0)     begin n_fail++; $display("FAIL timeout_early c%0d: got %b want 0", i, t4); end
        end
        step();                               // cycle 5
        n_checks++; if (g4 !== 16'h0000) begin n_fail++; $display("FAIL timeout_gap: got %h want 0000", g4); end
        n_checks++; if (t4 !== 1'b1)     begin n_fail++; $display("FAIL timeout_pulse: got %b want 1", t4); end
        n_checks++; if (v4 !== 1'b0)     begin n_fail++; $display("FAIL timeout_valid: got %b want 0", v4); end
        step();                               // cycle 6
        n_checks++; if (g4 !== 16'h0002) begin n_fail++; $display("FAIL timeout_next: got %h want 0002", g4); end
        n_checks++; if (t4 !== 1'b0)     begin n_fail++; $display("FAIL timeout_one_cycle: got %b want 0", t4); end
    endtask

    task automatic test_done_at_limit();
        // done together with a dropped request on the limit cycle is a normal release.
        do_reset();
        req = 16'h0001;
        step(); step(); step(); step();       // cycle 4: hold counter at limit
        done = 1'b1;
        req  = 16'h0000;
        step();
        done = 1'b0;
        n_checks++; if (g4 !== 16'h0000) begin n_fail++; $display("FAIL limit_gap: got %h want 0000", g4); end
        n_checks++; if (t4 !== 1'b0)     begin n_fail++; $display("FAIL limit_no_pulse: got %b want 0", t4); end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 16'h0004;
        step();
        n_checks++; if (g0 !== 16'h0004) begin n_fail++; $display("FAIL drop_grant: got %h want 0004", g0); end
        step();
        req = 16'h000A;                       // bit 2 dropped, bits 1 and 3 requesting
        step();
        n_checks++; if (g0 !== 16'h0000) begin n_fail++; $display("FAIL drop_gap: got %h want 0000", g0); end
        n_checks++; if (t0 !== 1'b0)     begin n_fail++; $display("FAIL drop_timeout: got %b want 0", t0); end
        step();
        n_checks++; if (g0 !== 16'h0008) begin n_fail++; $display("FAIL drop_ptr3: got %h want 0008", g0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req  = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (g0 !== (16'h0001 << i)) begin n_fail++; $display("FAIL b2b_grant %0d: got %h want %h", i, g0, 16'h0001 << i); end
            done = 1'b1;
            step();
            done = 1'b0;
            n_checks++; if (g0 !== 16'h0000) begin n_fail++; $display("FAIL b2b_gap %0d: got %h want 0000", i, g0); end
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 16'h0400;
        step();
        n_checks++; if (g0 !== 16'h0400) begin n_fail++; $display("FAIL midrst_grant: got %h want 0400", g0); end
        rst  = 1'b1;
        done = 1'b1;
        req  = 16'hFFFF;
        step();
        rst  = 1'b0;
        done = 1'b0;
        n_checks++; if (g0 !== 16'h0000) begin n_fail++; $display("FAIL midrst_gap: got %h want 0000", g0); end
        n_checks++; if (t4 !== 1'b0)     begin n_fail++; $display("FAIL midrst_timeout: got %b want 0", t4); end
        step();
        n_checks++; if (g0 !== 16'h0001) begin n_fail++; $display("FAIL midrst_restart: got %h want 0001", g0); end
        n_checks++; if (g4 !== 16'h0001) begin n_fail++; $display("FAIL midrst_restart4: got %h want 0001", g4); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_no_timeout_when_disabled();
        test_wrap();
        test_timeout();
        test_done_at_limit();
        test_req_drop();
        test_back_to_back();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
